// File: rtl/ret_stack_if.sv
// Call/return handshake between the program counter and the return-address stack.
// The stack drives the top-of-stack address and its fill/error status.
interface ret_stack_if #(
   parameter int INSTR_ADDR_SIZE = 6,
   parameter int STACK_DEPTH     = 8
);
   localparam int CW = $clog2(STACK_DEPTH + 1);

   logic                       call;
   logic                       ret;
   logic [INSTR_ADDR_SIZE-1:0] pc_addr;
   logic [INSTR_ADDR_SIZE-1:0] ret_addr;
   logic [CW-1:0]              count;
   logic                       empty;
   logic                       full;
   logic                       overflow;
   logic                       underflow;

   modport master (
      output call, ret, pc_addr,
      input  ret_addr, count, empty, full, overflow, underflow
   );

   modport slave (
      input  call, ret, pc_addr,
      output ret_addr, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/ret_stack.sv
// Return-address stack feeding the program counter; the top entry is presented
// combinationally so a ret can load it on the same edge that pops it.
module ret_stack #(
   parameter int INSTR_ADDR_SIZE = 6,
   parameter int STACK_DEPTH     = 8
) (
   input logic         clk,
   input logic         rst,
   ret_stack_if.slave  bus
);
   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam int AW = $clog2(STACK_DEPTH);

   logic [INSTR_ADDR_SIZE-1:0] mem [0:STACK_DEPTH-1];

   logic [CW-1:0]              count_reg, count_next;
   logic                       overflow_reg, overflow_next;
   logic                       underflow_reg, underflow_next;
   logic                       wr_en;
   logic [AW-1:0]              wr_idx;
   logic [AW-1:0]              top_idx;
   logic [INSTR_ADDR_SIZE-1:0] push_val;
   logic                       empty_w, full_w;

   assign empty_w  = (count_reg == '0);
   assign full_w   = (count_reg == CW'(STACK_DEPTH));
   assign top_idx  = AW'(count_reg - CW'(1));
   assign push_val = bus.pc_addr + INSTR_ADDR_SIZE'(1);

   always_comb begin
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      wr_en          = 1'b0;
      wr_idx         = AW'(count_reg);
      case ({bus.call, bus.ret})
         2'b10: begin
            if (full_w) begin
               overflow_next = 1'b1;
            end else begin
               wr_en      = 1'b1;
               count_next = count_reg + CW'(1);
            end
         end
         2'b01: begin
            if (empty_w) underflow_next = 1'b1;
            else         count_next     = count_reg - CW'(1);
         end
         2'b11: begin
            // Pop then push: the freed slot means a full stack can never overflow here.
            wr_en = 1'b1;
            if (empty_w) begin
               underflow_next = 1'b1;
               wr_idx         = '0;
               count_next     = CW'(1);
            end else begin
               wr_idx = top_idx;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // Entry contents carry no reset; count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[wr_idx] <= push_val;
   end

   assign bus.ret_addr  = empty_w ? '0 : mem[top_idx];
   assign bus.count     = count_reg;
   assign bus.empty     = empty_w;
   assign bus.full      = full_w;
   assign bus.overflow  = overflow_reg;
   assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_ret_stack.sv
// Randomized and directed check of ret_stack against a queue-based model of the
// call/return rules.
module tb_ret_stack;
   localparam int IA    = 6;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ret_stack_if #(.INSTR_ADDR_SIZE(IA), .STACK_DEPTH(DEPTH)) bus ();

   ret_stack #(.INSTR_ADDR_SIZE(IA), .STACK_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int  model_q[$];
   bit  model_ovf   = 1'b0;
   bit  model_unf   = 1'b0;
   bit  model_valid = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int model_top();
      return (model_q.size() > 0) ? model_q[$] : 0;
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".count"},     int'(bus.count),     model_q.size());
      check({tag, ".empty"},     int'(bus.empty),     int'(model_q.size() == 0));
      check({tag, ".full"},      int'(bus.full),      int'(model_q.size() == DEPTH));
      check({tag, ".overflow"},  int'(bus.overflow),  int'(model_ovf));
      check({tag, ".underflow"}, int'(bus.underflow), int'(model_unf));
      check({tag, ".ret_addr"},  int'(bus.ret_addr),  model_top());
   endtask

   // One clock cycle: drive, check the combinational top, advance model, check state.
   task automatic do_op(input bit c, input bit r, input int a, input bit rs, input string tag);
      int nxt;
      rst         = rs;
      bus.call    = c;
      bus.ret     = r;
      bus.pc_addr = IA'(a);
      #1;
      if (model_valid) check({tag, ".pre_ret_addr"}, int'(bus.ret_addr), model_top());
      nxt = (a + 1) % (1 << IA);
      if (rs) begin
         model_q.delete();
         model_ovf   = 1'b0;
         model_unf   = 1'b0;
         model_valid = 1'b1;
      end else if (c && !r) begin
         if (model_q.size() < DEPTH) model_q.push_back(nxt);
         else model_ovf = 1'b1;
      end else if (!c && r) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
         else model_unf = 1'b1;
      end else if (c && r) begin
         if (model_q.size() > 0) void'(model_q.pop_back());
         else model_unf = 1'b1;
         model_q.push_back(nxt);
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      bus.call = 1'b0;
      bus.ret  = 1'b0;
      if (model_valid) check_state(tag);
   endtask

   initial begin
      int exp_pop[3];
      exp_pop = '{21, 13, 6};
      bus.call    = 1'b0;
      bus.ret     = 1'b0;
      bus.pc_addr = '0;
      @(posedge clk);
      #1;

      // Reset beats a simultaneous call and ret.
      do_op(1, 1, 9, 1, "reset");
      check("reset.empty_lit", int'(bus.empty), 1);
      check("reset.ret_addr_lit", int'(bus.ret_addr), 0);

      // Push/pop order.
      do_op(1, 0, 5, 0, "push");
      do_op(1, 0, 12, 0, "push");
      do_op(1, 0, 20, 0, "push");
      for (int i = 0; i < 3; i++) begin
         #0 check("pop_order", int'(bus.ret_addr), exp_pop[i]);
         do_op(0, 1, 0, 0, "pop");
      end
      check("pop_order.count_lit", int'(bus.count), 0);

      // Overflow.
      do_op(0, 0, 0, 1, "reset");
      for (int i = 0; i < 9; i++) do_op(1, 0, i, 0, "ovf_push");
      check("ovf.full_lit", int'(bus.full), 1);
      check("ovf.count_lit", int'(bus.count), 8);
      check("ovf.flag_lit", int'(bus.overflow), 1);
      check("ovf.ret_addr_lit", int'(bus.ret_addr), 8);
      for (int i = 0; i < 8; i++) begin
         check("ovf_pop_lit", int'(bus.ret_addr), 8 - i);
         do_op(0, 1, 0, 0, "ovf_pop");
      end
      check("ovf.sticky_lit", int'(bus.overflow), 1);

      // Underflow.
      do_op(0, 0, 0, 1, "reset");
      do_op(0, 1, 0, 0, "unf_pop");
      check("unf.flag_lit", int'(bus.underflow), 1);
      do_op(1, 0, 3, 0, "unf_push");
      check("unf.ret_addr_lit", int'(bus.ret_addr), 4);
      check("unf.sticky_lit", int'(bus.underflow), 1);

      // Simultaneous call and ret.
      do_op(0, 0, 0, 1, "reset");
      do_op(1, 0, 9, 0, "push");
      do_op(1, 0, 29, 0, "push");
      check("both.pre_lit", int'(bus.ret_addr), 30);
      do_op(1, 1, 40, 0, "both");
      check("both.ret_addr_lit", int'(bus.ret_addr), 41);
      check("both.count_lit", int'(bus.count), 2);
      do_op(0, 0, 0, 1, "reset");
      do_op(1, 1, 7, 0, "both_empty");
      check("both_empty.ret_addr_lit", int'(bus.ret_addr), 8);
      check("both_empty.underflow_lit", int'(bus.underflow), 1);

      // Address wrap then mid-operation reset.
      do_op(0, 0, 0, 1, "reset");
      do_op(1, 0, 63, 0, "wrap");
      check("wrap.ret_addr_lit", int'(bus.ret_addr), 0);
      check("wrap.count_lit", int'(bus.count), 1);
      do_op(1, 0, 1, 0, "push");
      do_op(1, 0, 2, 0, "push");
      do_op(0, 0, 0, 1, "mid_reset");
      check("mid_reset.count_lit", int'(bus.count), 0);

      // Random traffic, biased toward calls so the full boundary gets exercised.
      for (int i = 0; i < 400; i++) begin
         bit c, r, rs;
         int a;
         c  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 45);
         rs = ($urandom_range(0, 59) == 0);
         a  = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 63));
         do_op(c, r, a, rs, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
